// File: rtl/prim_assembler_pkg.sv
// Shared definitions for the primitive assembler: default geometry,
// FSM state encoding and the counter-width helper used for sizing.
package prim_assembler_pkg;

    // Default geometry: 96-bit attribute words, vertex + color channels,
    // triangles.
    localparam int DEF_DATA_W = 96;
    localparam int DEF_NCH    = 2;
    localparam int DEF_NVERT  = 3;

    // FILL: reading and capturing vertices. HOLD: a full primitive is
    // presented downstream.
    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } asm_state_e;

    // Number of bits needed to encode values 0..value-1.
    // Evaluated at elaboration time to size the issue/fill counters.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/prim_slot_array.sv
// Vertex slot storage for the primitive assembler. Holds NVERT slots,
// each carrying all NCH attribute channels side by side. A slot is
// written at an index on capture, or the whole array slides down by
// one slot when a strip primitive is retired. The last slot is left
// untouched on a shift; it is refilled by the next capture.
module prim_slot_array
    import prim_assembler_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NCH    = DEF_NCH,
    parameter int NVERT  = DEF_NVERT,
    parameter int IDX_W  = clog2(DEF_NVERT + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_en,
    input  logic [IDX_W-1:0]              load_idx,
    input  logic                          shift_en,
    input  logic [NCH*DATA_W-1:0]         din,
    output logic [NVERT*NCH*DATA_W-1:0]   dout
);

    localparam int SLOT_W = NCH * DATA_W;

    logic [SLOT_W-1:0] slot_r [NVERT];

    // Slot registers: async clear, shift-down takes priority over load
    // (the controller never requests both in the same cycle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NVERT; v++) begin
                slot_r[v] <= {SLOT_W{1'b0}};
            end
        end else if (shift_en) begin
            for (int v = 0; v < NVERT - 1; v++) begin
                slot_r[v] <= slot_r[v+1];
            end
        end else if (load_en) begin
            for (int v = 0; v < NVERT; v++) begin
                if (load_idx == IDX_W'(v)) begin
                    slot_r[v] <= din;
                end
            end
        end
    end

    // Flatten slots so that slot v, channel c lands at (v*NCH+c)*DATA_W.
    for (genvar gv = 0; gv < NVERT; gv++) begin : g_flat
        assign dout[gv*SLOT_W +: SLOT_W] = slot_r[gv];
    end

endmodule

// File: rtl/prim_assembler.sv
// Primitive assembler: pulls vertex attribute words from NCH lockstep
// FIFOs with one shared read strobe, gathers NVERT vertices into a
// primitive and hands it off with a valid/ready handshake. Supports
// independent-primitive lists and strips (one new vertex per primitive,
// alternating winding parity).
module prim_assembler
    import prim_assembler_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NCH    = DEF_NCH,
    parameter int NVERT  = DEF_NVERT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NCH-1:0]                fifo_empty,
    input  logic [NCH*DATA_W-1:0]         fifo_dout,
    output logic                          fifo_rd_en,
    input  logic                          strip_mode,
    input  logic                          flush,
    output logic                          prim_valid,
    input  logic                          prim_ready,
    output logic [NVERT*NCH*DATA_W-1:0]   prim_data,
    output logic                          prim_odd
);

    localparam int CW = clog2(NVERT + 1);
    localparam logic [CW-1:0] NV_C    = CW'(NVERT);
    localparam logic [CW-1:0] NV_M1_C = CW'(NVERT - 1);
    localparam logic [CW-1:0] ZERO_C  = CW'(0);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    asm_state_e    state_r;
    logic [CW-1:0] issued_r;
    logic [CW-1:0] filled_r;
    logic          rd_en_r;
    logic          cap_r;
    logic          valid_r;
    logic          odd_r;
    logic          strip_r;
    logic          armed_r;

    logic          rd_next_s;
    logic          capture_s;
    logic          xfer_s;
    logic          mode_sample_s;
    logic          full_s;
    logic          load_en_s;
    logic          shift_en_s;
    logic [CW-1:0] filled_inc_s;

    // Next-cycle decisions: read issue, capture, hand-off and mode sampling.
    // armed_r holds off the first read until one edge after reset release.
    // A capture coinciding with flush is dropped; flush also wins over a
    // simultaneous hand-off.
    always_comb begin
        rd_next_s     = 1'b0;
        capture_s     = 1'b0;
        xfer_s        = 1'b0;
        mode_sample_s = 1'b0;
        full_s        = 1'b0;
        load_en_s     = 1'b0;
        shift_en_s    = 1'b0;
        filled_inc_s  = filled_r + ONE_C;

        rd_next_s     = armed_r & ~flush & (state_r == ST_FILL) & ~valid_r
                      & ~(|fifo_empty) & (issued_r < NV_C);
        capture_s     = cap_r & ~flush & (state_r == ST_FILL);
        xfer_s        = valid_r & prim_ready & ~flush;
        mode_sample_s = (state_r == ST_FILL) & (issued_r == ZERO_C)
                      & (filled_r == ZERO_C);
        full_s        = (filled_inc_s == NV_C);
        load_en_s     = capture_s;
        shift_en_s    = xfer_s & strip_r;
    end

    // Assembler FSM with registered strobe, valid, parity and counters.
    // cap_r marks the cycle where the FIFO word from last cycle's strobe
    // is present on fifo_dout; flush clears it so the word popped during
    // the flush cycle is discarded as well.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_FILL;
            issued_r <= ZERO_C;
            filled_r <= ZERO_C;
            rd_en_r  <= 1'b0;
            cap_r    <= 1'b0;
            valid_r  <= 1'b0;
            odd_r    <= 1'b0;
            strip_r  <= 1'b0;
            armed_r  <= 1'b0;
        end else begin
            armed_r <= 1'b1;
            if (flush) begin
                state_r  <= ST_FILL;
                issued_r <= ZERO_C;
                filled_r <= ZERO_C;
                rd_en_r  <= 1'b0;
                cap_r    <= 1'b0;
                valid_r  <= 1'b0;
                odd_r    <= 1'b0;
            end else begin
                rd_en_r <= rd_next_s;
                cap_r   <= rd_en_r;
                if (rd_next_s) begin
                    issued_r <= issued_r + ONE_C;
                end
                if (mode_sample_s) begin
                    strip_r <= strip_mode;
                end
                case (state_r)
                    ST_FILL: begin
                        if (capture_s) begin
                            filled_r <= filled_inc_s;
                            if (full_s) begin
                                state_r <= ST_HOLD;
                                valid_r <= 1'b1;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (xfer_s) begin
                            state_r <= ST_FILL;
                            valid_r <= 1'b0;
                            if (strip_r) begin
                                // Keep the last NVERT-1 vertices; one new read completes
                                // the next primitive.
                                issued_r <= NV_M1_C;
                                filled_r <= NV_M1_C;
                                odd_r    <= ~odd_r;
                            end else begin
                                issued_r <= ZERO_C;
                                filled_r <= ZERO_C;
                                odd_r    <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_r  <= ST_FILL;
                        issued_r <= ZERO_C;
                        filled_r <= ZERO_C;
                        valid_r  <= 1'b0;
                        odd_r    <= 1'b0;
                    end
                endcase
            end
        end
    end

    prim_slot_array #(
        .DATA_W (DATA_W),
        .NCH    (NCH),
        .NVERT  (NVERT),
        .IDX_W  (CW)
    ) u_slots (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (load_en_s),
        .load_idx (filled_r),
        .shift_en (shift_en_s),
        .din      (fifo_dout),
        .dout     (prim_data)
    );

    assign fifo_rd_en = rd_en_r;
    assign prim_valid = valid_r;
    assign prim_odd   = odd_r;

endmodule

// File: tb/tb_prim_assembler.sv
// Directed testbench for prim_assembler (DATA_W=96, NCH=2, NVERT=3).
// Two behavioral FIFOs feed the DUT; each scenario task drives stimulus
// and compares outputs against hand-derived vertex words.
module tb_prim_assembler;

    localparam int DW = 96;
    localparam int NC = 2;
    localparam int NV = 3;
    localparam int PW = NV * NC * DW;

    logic              clk;
    logic              rst_n;
    logic [NC-1:0]     fifo_empty;
    logic [NC*DW-1:0]  fifo_dout;
    logic              fifo_rd_en;
    logic              strip_mode;
    logic              flush;
    logic              prim_valid;
    logic              prim_ready;
    logic [PW-1:0]     prim_data;
    logic              prim_odd;

    int checks = 0;
    int errors = 0;

    // FIFO model: registered read data, valid the cycle after the strobe
    logic [DW-1:0] mem [NC][64];
    logic [DW-1:0] dout_q [NC];
    int            rp [NC] = '{0, 0};
    int            wp [NC] = '{0, 0};
    logic [NC-1:0] force_empty = 2'b00;
    int            rd_count = 0;
    int            cyc = 0;

    prim_assembler #(.DATA_W(DW), .NCH(NC), .NVERT(NV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .strip_mode (strip_mode),
        .flush      (flush),
        .prim_valid (prim_valid),
        .prim_ready (prim_ready),
        .prim_data  (prim_data),
        .prim_odd   (prim_odd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = {(rp[1] == wp[1]) | force_empty[1], (rp[0] == wp[0]) | force_empty[0]};
    assign fifo_dout  = {dout_q[1], dout_q[0]};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en === 1'b1) begin
            rd_count <= rd_count + 1;
            for (int c = 0; c < NC; c++) begin
                if (rp[c] != wp[c]) begin
                    dout_q[c] <= mem[c][rp[c]];
                    rp[c]     <= rp[c] + 1;
                end
            end
        end
    end

    // Attribute word of vertex k on channel c
    function automatic logic [DW-1:0] vword(input int k, input int c);
        return {32'(k), 32'hC0DE_0000 + 32'(c), 32'(k * 3 + c)};
    endfunction

    function automatic logic [PW-1:0] exp_prim(input int a, input int b, input int d);
        logic [PW-1:0] r;
        int ks [NV];
        ks[0] = a; ks[1] = b; ks[2] = d;
        r = '0;
        for (int v = 0; v < NV; v++) begin
            for (int c = 0; c < NC; c++) begin
                r[(v * NC + c) * DW +: DW] = vword(ks[v], c);
            end
        end
        return r;
    endfunction

    task automatic load(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < NC; c++) begin
                mem[c][wp[c]] = vword(first + i, c);
                wp[c] = wp[c] + 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd(input int budget, input string name, output int at);
        bit got;
        got = 1'b0;
        at  = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (fifo_rd_en === 1'b1) begin
                got = 1'b1;
                at  = cyc;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s: no fifo_rd_en within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_valid(input int budget, input string name, output int at);
        bit got;
        got = 1'b0;
        at  = 0;
        for (int i = 0; i < budget; i++) begin
            if (prim_valid === 1'b1) begin
                got = 1'b1;
                at  = cyc;
                break;
            end
            step();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s: no prim_valid within %0d cycles", name, budget);
        end
    endtask

    task automatic check_prim(input string name, input logic [PW-1:0] exp_d, input logic exp_o);
        checks++;
        if (prim_data !== exp_d) begin
            errors++;
            $display("FAIL %s data: got %h want %h", name, prim_data[DW-1:0], exp_d[DW-1:0]);
        end
        checks++;
        if (prim_odd !== exp_o) begin
            errors++;
            $display("FAIL %s odd: got %b want %b", name, prim_odd, exp_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; strip_mode = 1'b0; flush = 1'b0; prim_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
        checks++; if (prim_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", prim_valid); end
        checks++; if (prim_odd !== 1'b0) begin errors++; $display("FAIL reset_odd: got %b want 0", prim_odd); end
        checks++; if (prim_data !== '0) begin errors++; $display("FAIL reset_data: got nonzero want 0"); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_list();
        int t_rd, t_v, r0;
        r0 = rd_count;
        strip_mode = 1'b0; prim_ready = 1'b1;
        load(101, 6);
        wait_rd(20, "list_first_rd", t_rd);
        wait_valid(20, "list_prim0", t_v);
        checks++;
        if (t_v - t_rd !== NV + 1) begin
            errors++; $display("FAIL list_latency: got %0d want %0d", t_v - t_rd, NV + 1);
        end
        check_prim("list_prim0", exp_prim(101, 102, 103), 1'b0);
        step();
        wait_valid(20, "list_prim1", t_v);
        check_prim("list_prim1", exp_prim(104, 105, 106), 1'b0);
        repeat (8) step();
        checks++;
        if (rd_count - r0 !== 6) begin
            errors++; $display("FAIL list_reads: got %0d want 6", rd_count - r0);
        end
    endtask

    task automatic test_strip();
        int t_v, r0;
        r0 = rd_count;
        strip_mode = 1'b1; prim_ready = 1'b1;
        step();
        load(201, 5);
        wait_valid(20, "strip_prim0", t_v);
        check_prim("strip_prim0", exp_prim(201, 202, 203), 1'b0);
        step();
        wait_valid(20, "strip_prim1", t_v);
        check_prim("strip_prim1", exp_prim(202, 203, 204), 1'b1);
        step();
        wait_valid(20, "strip_prim2", t_v);
        check_prim("strip_prim2", exp_prim(203, 204, 205), 1'b0);
        repeat (6) step();
        checks++;
        if (rd_count - r0 !== 5) begin
            errors++; $display("FAIL strip_reads: got %0d want 5", rd_count - r0);
        end
        // Leave strip history behind with a flush; parity must clear.
        strip_mode = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (prim_odd !== 1'b0) begin
            errors++; $display("FAIL strip_flush_odd: got %b want 0", prim_odd);
        end
        step();
    endtask

    task automatic test_stall();
        int t_rd, t_v, r0;
        r0 = rd_count;
        prim_ready = 1'b1;
        load(301, 3);
        wait_rd(20, "stall_first_rd", t_rd);
        force_empty[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (fifo_rd_en !== 1'b0) begin
                errors++; $display("FAIL stall_rd_en cycle %0d: got %b want 0", i, fifo_rd_en);
            end
        end
        force_empty[1] = 1'b0;
        wait_valid(30, "stall_prim", t_v);
        check_prim("stall_prim", exp_prim(301, 302, 303), 1'b0);
        step();
        repeat (4) step();
        checks++;
        if (rd_count - r0 !== 3) begin
            errors++; $display("FAIL stall_reads: got %0d want 3", rd_count - r0);
        end
    endtask

    task automatic test_hold();
        int t_v;
        prim_ready = 1'b0;
        load(401, 6);
        wait_valid(20, "hold_prim0", t_v);
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (prim_data !== exp_prim(401, 402, 403) || prim_valid !== 1'b1) begin
                errors++; $display("FAIL hold_data cycle %0d: got valid %b data %h", i, prim_valid, prim_data[DW-1:0]);
            end
            checks++;
            if (fifo_rd_en !== 1'b0) begin
                errors++; $display("FAIL hold_rd_en cycle %0d: got %b want 0", i, fifo_rd_en);
            end
        end
        prim_ready = 1'b1;
        step();
        wait_valid(20, "hold_prim1", t_v);
        check_prim("hold_prim1", exp_prim(404, 405, 406), 1'b0);
        step();
    endtask

    task automatic test_flush();
        int t_rd, t_v, r0;
        r0 = rd_count;
        prim_ready = 1'b1;
        load(501, 5);
        wait_rd(20, "flush_rd1", t_rd);
        wait_rd(5, "flush_rd2", t_rd);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (fifo_rd_en !== 1'b0 || prim_valid !== 1'b0) begin
            errors++; $display("FAIL flush_clear: got rd %b valid %b want 0 0", fifo_rd_en, prim_valid);
        end
        wait_valid(20, "flush_prim", t_v);
        check_prim("flush_prim", exp_prim(503, 504, 505), 1'b0);
        step();
        repeat (4) step();
        checks++;
        if (rd_count - r0 !== 5) begin
            errors++; $display("FAIL flush_reads: got %0d want 5", rd_count - r0);
        end
    endtask

    task automatic test_reset_mid();
        int t_rd, t_v;
        prim_ready = 1'b1;
        load(601, 6);
        wait_rd(20, "rstmid_rd1", t_rd);
        wait_rd(5, "rstmid_rd2", t_rd);
        wait_rd(5, "rstmid_rd3", t_rd);
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b0 || prim_valid !== 1'b0 || prim_odd !== 1'b0) begin
            errors++; $display("FAIL rstmid_ctrl: got rd %b valid %b odd %b want 0", fifo_rd_en, prim_valid, prim_odd);
        end
        checks++;
        if (prim_data !== '0) begin
            errors++; $display("FAIL rstmid_data: got %h want 0", prim_data[DW-1:0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (fifo_rd_en !== 1'b0) begin
            errors++; $display("FAIL rstmid_first_edge_rd: got %b want 0", fifo_rd_en);
        end
        wait_valid(20, "rstmid_prim", t_v);
        check_prim("rstmid_prim", exp_prim(604, 605, 606), 1'b0);
        step();
    endtask

    initial begin
        test_reset();
        test_list();
        test_strip();
        test_stall();
        test_hold();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/prim_assembler.md
PRIM_ASSEMBLER -- requirements
Module: prim_assembler

Interface
REQ-001 Parameter DATA_W, default 96: width of one attribute word per channel.
REQ-002 Parameter NCH, default 2: attribute channels read in lockstep (ch0 = vertex, ch1 = color).
REQ-003 Parameter NVERT, default 3: vertices per primitive, legal range 2..4; strip mode requires NVERT>=3.
REQ-004 clk  in  1  single clock, all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 fifo_empty  in  NCH  per-channel upstream FIFO empty flag.
REQ-007 fifo_dout  in  NCH*DATA_W  per-channel FIFO read data; channel c at bits [c*DATA_W +: DATA_W]; valid 1 cycle after rd_en.
REQ-008 fifo_rd_en  out  1  shared read strobe to all NCH FIFOs.
REQ-009 strip_mode  in  1  0 = independent-primitive list, 1 = strip.
REQ-010 flush  in  1  synchronous restart; discards partial primitive and strip history.
REQ-011 prim_valid  out  1  assembled primitive available.
REQ-012 prim_ready  in  1  consumer accepts; transfer occurs when prim_valid and prim_ready are both 1 at a clock edge.
REQ-013 prim_data  out  NVERT*NCH*DATA_W  slot v, channel c at bits [(v*NCH+c)*DATA_W +: DATA_W].
REQ-014 prim_odd  out  1  strip winding parity of the current primitive (0 for list mode).

Function
REQ-015 fifo_rd_en SHALL be a registered output, asserted only when all fifo_empty bits are 0, prim_valid is 0, issued < NVERT, and flush is 0.
REQ-016 Back-to-back reads SHALL be permitted; counter issued (0..NVERT) increments per strobe, counter filled (0..NVERT) per capture.
REQ-017 Data SHALL be captured from fifo_dout into slot filled exactly one cycle after each fifo_rd_en, for all NCH channels simultaneously.
REQ-018 Any channel going empty SHALL stall reads for all channels; in-flight reads SHALL still be captured.
REQ-019 FSM states: FILL (reading/capturing) and HOLD (prim_valid=1); FILL->HOLD when filled reaches NVERT; HOLD->FILL on transfer.
REQ-020 Latency: with non-empty FIFOs and an empty assembler, first fifo_rd_en at cycle T gives prim_valid=1 from cycle T+NVERT+1.
REQ-021 prim_data and prim_odd SHALL remain stable while prim_valid=1 and prim_ready=0.
REQ-022 On transfer in list mode: issued=filled=0, prim_odd=0.
REQ-023 On transfer in strip mode: slot v <= slot v+1 for v<NVERT-1; issued=filled=NVERT-1; prim_odd toggles; next primitive needs one read.
REQ-024 strip_mode SHALL be sampled only in FILL with filled=0 and issued=0; changes at other times take effect at that point.
REQ-025 flush SHALL clear issued, filled, prim_valid and prim_odd next edge; a capture due in that edge or the following is discarded; flush overrides a simultaneous transfer.
REQ-026 Counter widths SHALL be clog2(NVERT+1); no wrap-around beyond NVERT is reachable.

Reset
REQ-027 rst_n=0 SHALL immediately force fifo_rd_en=0, prim_valid=0, prim_odd=0, issued=filled=0, state FILL, prim_data=0, regardless of clock, including mid-read.
REQ-028 The first fifo_rd_en after release SHALL occur no earlier than the second rising edge following rst_n rising.

Structure
REQ-029 A shared package/include SHALL hold FSM state encodings, default DATA_W/NCH/NVERT, and the clog2 function.
REQ-030 One sub-module prim_slot_array SHALL hold the NVERT x NCH slot registers with load-at-index and shift-down controls.

Verification
REQ-031 List, NVERT=3, FIFOs pre-loaded v=1..6, prim_ready=1 -> two primitives {1,2,3},{4,5,6}, first prim_valid at T+4, fifo_rd_en pulses exactly 6.
REQ-032 Strip, v=1..5 -> primitives {1,2,3},{2,3,4},{3,4,5} with prim_odd 0,1,0; 5 reads total.
REQ-033 ch1 empty for 5 cycles after first read -> no fifo_rd_en during stall, prim_data ch0/ch1 still paired, primitive correct.
REQ-034 prim_ready=0 for 10 cycles in HOLD -> prim_data constant, fifo_rd_en=0 throughout.
REQ-035 flush asserted one cycle after second fifo_rd_en -> second vertex discarded; next primitive built from vertices 3,4,5.
REQ-036 rst_n pulsed low mid-fill (filled=2) -> outputs zero asynchronously; after release, clean primitive from next three FIFO words.
